// File: rtl/phase_readout_serializer_pkg.sv
// Shared definitions for the phase readout serializer: phase width, FSM encodings, CRC-8 helper.
`default_nettype none

package phase_readout_serializer_pkg;

  localparam int PHASE_W = 4;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_WATCH   = 3'd1;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
  localparam logic [STATE_W-1:0] ST_SHIFT   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  // One serial step of an MSB-first CRC-8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_readout_serializer_if.sv
// Host-side bus of the phase readout serializer: arm/flags/phases in, framed serial stream out.
`default_nettype none

interface phase_readout_serializer_if #(
  parameter int N = 210
);

  logic             arm;
  logic [N-1:0]     state_changed;
  logic [0:4*N-1]   phi_in;
  logic             rd_ready;
  logic             data_out;
  logic             data_valid;
  logic             frame_start;
  logic             frame_done;
  logic             steady;
  logic             timeout;

  modport master (
    output arm, state_changed, phi_in, rd_ready,
    input  data_out, data_valid, frame_start, frame_done, steady, timeout
  );

  modport slave (
    input  arm, state_changed, phi_in, rd_ready,
    output data_out, data_valid, frame_start, frame_done, steady, timeout
  );

endinterface

`default_nettype wire

// File: rtl/phase_readout_serializer_convergence_detector.sv
// Counts quiet cycles and total wait cycles while enabled; flags convergence or timeout.
`default_nettype none

module convergence_detector #(
  parameter int STABLE_CYC = 8,
  parameter int MAX_WAIT   = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic changed,
  output logic steady_hit,
  output logic timeout_hit
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] STAB_TOP = SW'(STABLE_CYC);
  localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  logic [SW-1:0] stab_cnt, stab_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;

  // Hits are judged on the count this cycle produces, so CAPTURE follows immediately.
  always_comb begin
    stab_nxt = stab_cnt;
    wait_nxt = wait_cnt;
    if (changed)
      stab_nxt = '0;
    else if (stab_cnt != STAB_TOP)
      stab_nxt = stab_cnt + STAB_ONE;
    if (wait_cnt != WAIT_TOP)
      wait_nxt = wait_cnt + WAIT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
      wait_cnt <= '0;
    end else if (!enable) begin
      stab_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      stab_cnt <= stab_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign steady_hit  = enable && (stab_nxt == STAB_TOP);
  assign timeout_hit = enable && (wait_nxt == WAIT_TOP);

endmodule

`default_nettype wire

// File: rtl/phase_readout_serializer.sv
// Waits for network convergence, snapshots the phase vector and streams it out serially.
// Optional CRC-8 trailer enabled by defining PHASE_READOUT_CRC8_EN.
`default_nettype none

module phase_readout_serializer
  import phase_readout_serializer_pkg::*;
#(
  parameter int N          = 210,
  parameter int STABLE_CYC = 8,
  parameter int MAX_WAIT   = 4096
) (
  input  logic                         sclk,
  input  logic                         re,
  phase_readout_serializer_if.slave    bus
);

  localparam int PHASE_BITS = PHASE_W * N;
`ifdef PHASE_READOUT_CRC8_EN
  localparam int FRAME_LEN = PHASE_BITS + 8;
`else
  localparam int FRAME_LEN = PHASE_BITS;
`endif
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int PW = $clog2(PHASE_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic [STATE_W-1:0]    state, state_nxt;
  logic [0:PHASE_BITS-1] snap;
  logic [IW-1:0]         bit_idx;
  logic                  steady_q, timeout_q;
  logic                  steady_hit, timeout_hit;
  logic                  accept;
  logic                  phase_bit;
  logic                  tx_bit;

  convergence_detector #(
    .STABLE_CYC (STABLE_CYC),
    .MAX_WAIT   (MAX_WAIT)
  ) u_detector (
    .clk         (sclk),
    .rst         (re),
    .enable      (state == ST_WATCH),
    .changed     (|bus.state_changed),
    .steady_hit  (steady_hit),
    .timeout_hit (timeout_hit)
  );

  assign accept    = (state == ST_SHIFT) && bus.rd_ready;
  assign phase_bit = snap[bit_idx[PW-1:0]];

  always_ff @(posedge sclk or posedge re) begin
    if (re)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.arm) state_nxt = ST_WATCH;
      ST_WATCH:   if (steady_hit || timeout_hit) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_SHIFT;
      ST_SHIFT:   if (accept && (bit_idx == LAST_IDX)) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.data_out    = 1'b0;
    bus.data_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_done  = 1'b0;
    if (state == ST_SHIFT) begin
      bus.data_out    = tx_bit;
      bus.data_valid  = 1'b1;
      bus.frame_start = (bit_idx == '0);
    end
    if (state == ST_DONE)
      bus.frame_done = 1'b1;
    bus.steady  = steady_q;
    bus.timeout = timeout_q;
  end

  // Steady takes priority when both conditions land in the same cycle.
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      steady_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else if ((state == ST_IDLE) && bus.arm) begin
      steady_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state == ST_WATCH) begin
      if (steady_hit)
        steady_q <= 1'b1;
      else if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      snap    <= '0;
      bit_idx <= '0;
    end else if (state == ST_CAPTURE) begin
      snap    <= bus.phi_in;
      bit_idx <= '0;
    end else if (accept) begin
      bit_idx <= bit_idx + IDX_ONE;
    end
  end

`ifdef PHASE_READOUT_CRC8_EN
  logic [7:0] crc;
  logic       in_crc;

  assign in_crc = (bit_idx >= IW'(PHASE_BITS));
  assign tx_bit = in_crc ? crc[7] : phase_bit;

  // Accumulates over accepted phase bits, then shifts itself out MSB first.
  always_ff @(posedge sclk or posedge re) begin
    if (re)
      crc <= 8'h00;
    else if (state == ST_CAPTURE)
      crc <= 8'h00;
    else if (accept)
      crc <= in_crc ? {crc[6:0], 1'b0} : crc8_step(crc, phase_bit);
  end
`else
  assign tx_bit = phase_bit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phase_readout_serializer.sv
// Directed self-checking bench for phase_readout_serializer (N=4, STABLE_CYC=3, MAX_WAIT=20).
`default_nettype none

module tb_phase_readout_serializer;

  localparam int N = 4;
`ifdef PHASE_READOUT_CRC8_EN
  localparam int FL = 24;
`else
  localparam int FL = 16;
`endif

  logic sclk;
  logic re;
  int   n_total;
  int   n_bad;

  phase_readout_serializer_if #(.N(N)) bus ();

  phase_readout_serializer #(
    .N          (N),
    .STABLE_CYC (3),
    .MAX_WAIT   (20)
  ) dut (
    .sclk (sclk),
    .re   (re),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.data_out, bus.data_valid, bus.frame_start, bus.frame_done, bus.steady, bus.timeout};
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  // Cycles from the arm edge until data_valid; toggle drives state_changed every 2nd cycle.
  task automatic wait_valid(input bit toggle, output int lat);
    lat = 0;
    while (!bus.data_valid && lat < 100) begin
      bus.state_changed = (toggle && (lat % 2 == 1)) ? 4'b0100 : 4'b0000;
      tick();
      lat++;
    end
    bus.state_changed = '0;
  endtask

  task automatic recv_frame(input logic [15:0] exp, input int hold_at, input int hold_len,
                            output logic [15:0] ph, output logic [7:0] cr,
                            output int nbits, output int dones, output int errs);
    int stall;
    int guard;
    ph = '0; cr = '0; nbits = 0; dones = 0; errs = 0; stall = 0; guard = 0;
    while (dones == 0 && guard < 300) begin
      if (nbits == hold_at && stall < hold_len) begin
        bus.rd_ready = 1'b0;
        stall++;
      end else begin
        bus.rd_ready = 1'b1;
      end
      #1;
      if (bus.frame_done) dones++;
      if (bus.data_valid) begin
        if (bus.frame_start != (nbits == 0)) errs++;
        if (nbits < 16 && bus.data_out != exp[4'(15 - nbits)]) errs++;
        if (bus.rd_ready) begin
          if (nbits < 16) ph = {ph[14:0], bus.data_out};
          else            cr = {cr[6:0], bus.data_out};
          nbits++;
        end
      end
      @(posedge sclk);
      #1;
      guard++;
    end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.frame_done) dones++;
      if (bus.data_valid) errs++;
      tick();
    end
  endtask

  logic [15:0] ph;
  logic [7:0]  cr;
  int          nbits, dones, errs, lat;

  initial begin
    n_total = 0;
    n_bad   = 0;
    re = 1'b1;
    bus.arm = 1'b0;
    bus.state_changed = '0;
    bus.phi_in = '0;
    bus.rd_ready = 1'b1;
    repeat (3) tick();
    check_val("reset_outs", 32'(outs()), 32'h0);
    re = 1'b0;
    tick();

    // 1: clean convergence
    bus.phi_in = 16'hA5C3;
    do_arm();
    wait_valid(1'b0, lat);
    check_val("t1_latency", lat, 4);
    check_val("t1_steady", 32'(bus.steady), 1);
    check_val("t1_timeout", 32'(bus.timeout), 0);
    recv_frame(16'hA5C3, -1, 0, ph, cr, nbits, dones, errs);
    check_val("t1_frame", 32'(ph), 32'hA5C3);
    check_val("t1_nbits", nbits, FL);
    check_val("t1_done_once", dones, 1);
    check_val("t1_errs", errs, 0);

    // 2: never settles, forced capture
    bus.phi_in = 16'h5A0F;
    do_arm();
    check_val("t2_arm_clears_steady", 32'(bus.steady), 0);
    wait_valid(1'b1, lat);
    check_val("t2_latency", lat, 21);
    check_val("t2_timeout", 32'(bus.timeout), 1);
    check_val("t2_steady", 32'(bus.steady), 0);
    recv_frame(16'h5A0F, -1, 0, ph, cr, nbits, dones, errs);
    check_val("t2_frame", 32'(ph), 32'h5A0F);
    check_val("t2_timeout_hold", 32'(bus.timeout), 1);

    // 3: backpressure at bit 6; phi_in changes after capture must not leak in
    bus.phi_in = 16'h3C96;
    do_arm();
    wait_valid(1'b0, lat);
    bus.phi_in = 16'hFFFF;
    recv_frame(16'h3C96, 6, 5, ph, cr, nbits, dones, errs);
    check_val("t3_frame", 32'(ph), 32'h3C96);
    check_val("t3_nbits", nbits, FL);
    check_val("t3_errs", errs, 0);

    // 4: reset in the middle of the frame
    bus.phi_in = 16'hB4E1;
    do_arm();
    wait_valid(1'b0, lat);
    bus.rd_ready = 1'b1;
    repeat (9) tick();
    check_val("t4_bit9", 32'(bus.data_out), 32'(1'b1));
    check_val("t4_steady_pre", 32'(bus.steady), 1);
    re = 1'b1;
    #1;
    check_val("t4_reset_outs", 32'(outs()), 32'h0);
    tick();
    check_val("t4_no_done", 32'(bus.frame_done), 0);
    re = 1'b0;
    tick();
    do_arm();
    wait_valid(1'b0, lat);
    recv_frame(16'hB4E1, -1, 0, ph, cr, nbits, dones, errs);
    check_val("t4_frame", 32'(ph), 32'hB4E1);
    check_val("t4_nbits", nbits, FL);
    check_val("t4_done_once", dones, 1);

    // 5: arm while shifting is ignored
    bus.phi_in = 16'h6D29;
    bus.rd_ready = 1'b0;
    do_arm();
    wait_valid(1'b0, lat);
    do_arm();
    check_val("t5_steady", 32'(bus.steady), 1);
    check_val("t5_still_first", 32'({bus.data_valid, bus.frame_start}), 32'h3);
    recv_frame(16'h6D29, -1, 0, ph, cr, nbits, dones, errs);
    check_val("t5_frame", 32'(ph), 32'h6D29);
    check_val("t5_errs", errs, 0);
    check_val("t5_done_once", dones, 1);

    // 6: single set bit, CRC trailer when enabled
    bus.phi_in = 16'h0001;
    do_arm();
    wait_valid(1'b0, lat);
    recv_frame(16'h0001, -1, 0, ph, cr, nbits, dones, errs);
    check_val("t6_frame", 32'(ph), 32'h0001);
    check_val("t6_nbits", nbits, FL);
`ifdef PHASE_READOUT_CRC8_EN
    check_val("t6_crc", 32'(cr), 32'h07);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
